// File: rtl/pipe_stage_skid.sv
// Valid/ready inter-stage register with optional 2-entry skid (main + skid) for the P7 core.
// Optional PIPE_PERF_EN macro adds saturating stall_cnt / bubble_cnt counters.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
`ifdef PIPE_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic              out_bd
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [EXC_W-1:0]  main_exc_q, main_exc_d;
  logic              main_bd_q, main_bd_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [EXC_W-1:0]  skid_exc_q, skid_exc_d;
  logic              skid_bd_q, skid_bd_d;

  logic              accept_s;
  logic              main_free_s;
  logic [DATA_W-1:0] cap_instr_s;

  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !skid_v_q;
    end else begin : g_comb_ready
      assign in_ready = !main_v_q || out_ready;
    end
  endgenerate

  assign accept_s    = in_valid && in_ready;
  assign main_free_s = !main_v_q || out_ready;
  // A beat carrying a fetch exception is stored as a nop.
  assign cap_instr_s = (in_exc != {EXC_W{1'b0}}) ? {DATA_W{1'b0}} : in_instr;

  // Next-state for main and skid entries; flush wins over transfer and accept.
  always_comb begin
    main_v_d     = main_v_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_exc_d   = main_exc_q;
    main_bd_d    = main_bd_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_exc_d   = skid_exc_q;
    skid_bd_d    = skid_bd_q;
    if (flush) begin
      main_v_d     = 1'b0;
      main_instr_d = {DATA_W{1'b0}};
      main_pc_d    = {PC_W{1'b0}};
      main_exc_d   = {EXC_W{1'b0}};
      main_bd_d    = (main_v_q && !out_ready && in_valid) ? in_bd : 1'b0;
      skid_v_d     = 1'b0;
      skid_instr_d = {DATA_W{1'b0}};
      skid_pc_d    = {PC_W{1'b0}};
      skid_exc_d   = {EXC_W{1'b0}};
      skid_bd_d    = 1'b0;
    end else if (main_free_s) begin
      if (skid_v_q) begin
        main_v_d     = 1'b1;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        main_exc_d   = skid_exc_q;
        main_bd_d    = skid_bd_q;
        skid_v_d     = 1'b0;
        skid_instr_d = {DATA_W{1'b0}};
        skid_pc_d    = {PC_W{1'b0}};
        skid_exc_d   = {EXC_W{1'b0}};
        skid_bd_d    = 1'b0;
      end else if (accept_s) begin
        main_v_d     = 1'b1;
        main_instr_d = cap_instr_s;
        main_pc_d    = in_pc;
        main_exc_d   = in_exc;
        main_bd_d    = in_bd;
      end else begin
        main_v_d     = 1'b0;
        main_instr_d = {DATA_W{1'b0}};
        main_pc_d    = {PC_W{1'b0}};
        main_exc_d   = {EXC_W{1'b0}};
        main_bd_d    = 1'b0;
      end
    end else if (accept_s) begin
      // Main is holding; only reachable with SKID=1 since in_ready tracks main otherwise.
      skid_v_d     = 1'b1;
      skid_instr_d = cap_instr_s;
      skid_pc_d    = in_pc;
      skid_exc_d   = in_exc;
      skid_bd_d    = in_bd;
    end else begin
      skid_v_d     = skid_v_q;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q     <= 1'b0;
      main_instr_q <= {DATA_W{1'b0}};
      main_pc_q    <= {PC_W{1'b0}};
      main_exc_q   <= {EXC_W{1'b0}};
      main_bd_q    <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= {DATA_W{1'b0}};
      skid_pc_q    <= {PC_W{1'b0}};
      skid_exc_q   <= {EXC_W{1'b0}};
      skid_bd_q    <= 1'b0;
    end else begin
      main_v_q     <= main_v_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_exc_q   <= main_exc_d;
      main_bd_q    <= main_bd_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_exc_q   <= skid_exc_d;
      skid_bd_q    <= skid_bd_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_instr = main_instr_q;
  assign out_pc    = main_pc_q;
  assign out_exc   = main_exc_q;
  assign out_bd    = main_bd_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Saturating performance counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (main_v_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (!main_v_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        bubble_cnt_q <= bubble_cnt_q;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid (SKID=1): vector table, FIFO scoreboard,
// and directed skid / flush / async-reset sequences.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_bd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  out_exc;
  logic        out_bd;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  pipe_stage_skid #(.DATA_W(32), .PC_W(32), .EXC_W(5), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc),
`ifdef PIPE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .out_bd(out_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } beat_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] exp_instr;
  } vec_t;

  beat_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle; scoreboard tracks accepts and checks transfers before the edge.
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] exc, input logic bd, input logic ordy, input logic fl);
    beat_t e;
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    in_exc    = exc;
    in_bd     = bd;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: transfer of pc %h with no beat expected", out_pc);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", out_instr, e.instr);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_exc", {27'd0, out_exc}, {27'd0, e.exc});
          chk("sb_bd", {31'd0, out_bd}, {31'd0, e.bd});
        end
      end
      if (in_valid && in_ready) begin
        e.instr = (exc != 5'd0) ? 32'd0 : instr;
        e.pc    = pc;
        e.exc   = exc;
        e.bd    = bd;
        sb.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h2401_0005, 32'h0000_3000, 5'd0,  1'b0, 32'h2401_0005};
    vecs[1] = '{32'h8C22_0000, 32'h0000_3004, 5'd4,  1'b0, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_4000, 5'd0,  1'b1, 32'hFFFF_FFFF};
    vecs[3] = '{32'h1234_5678, 32'h0000_4004, 5'd31, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'h0000_4008, 5'd0,  1'b0, 32'h0000_0000};
    vecs[5] = '{32'hA5A5_A5A5, 32'hFFFF_FFFC, 5'd12, 1'b0, 32'h0000_0000};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    in_exc = 5'd0; in_bd = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_exc", {27'd0, out_exc}, 32'd0);
    chk("rst_out_bd", {31'd0, out_bd}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Table: one beat per cycle with out_ready=1, visible the following cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].exc, vecs[i].bd, 1'b1, 1'b0);
      chk("vec_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_instr", out_instr, vecs[i].exp_instr);
      chk("vec_pc", out_pc, vecs[i].pc);
      chk("vec_exc", {27'd0, out_exc}, {27'd0, vecs[i].exc});
      chk("vec_bd", {31'd0, out_bd}, {31'd0, vecs[i].bd});
    end
    idle(1'b1);
    chk("bubble_valid", {31'd0, out_valid}, 32'd0);
    chk("bubble_instr", out_instr, 32'd0);
    chk("bubble_pc", out_pc, 32'd0);
    chk("bubble_exc", {27'd0, out_exc}, 32'd0);

    // Skid fill with downstream stalled, then drain in order.
    drive(1'b1, 32'h0000_0001, 32'h0000_3008, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("skid_ready_1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h0000_0002, 32'h0000_300C, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("skid_ready_0", {31'd0, in_ready}, 32'd0);
    chk("skid_head_pc", out_pc, 32'h0000_3008);
    drive(1'b1, 32'h0000_0003, 32'h0000_3FFF, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("skid_hold_pc", out_pc, 32'h0000_3008);
    idle(1'b1);
    chk("skid_drain_pc", out_pc, 32'h0000_300C);
    chk("skid_drain_bd", {31'd0, out_bd}, 32'd1);
    chk("skid_ready_back", {31'd0, in_ready}, 32'd1);
    idle(1'b1);
    chk("skid_empty", {31'd0, out_valid}, 32'd0);

    // Flush while holding with a delay-slot beat arriving keeps its bd flag.
    drive(1'b1, 32'h0000_0010, 32'h0000_3010, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0011, 32'h0000_3014, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_instr", out_instr, 32'd0);
    chk("fl_pc", out_pc, 32'd0);
    chk("fl_exc", {27'd0, out_exc}, 32'd0);
    chk("fl_bd_hold", {31'd0, out_bd}, 32'd1);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h0000_0010, 32'h0000_3010, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h0000_0011, 32'h0000_3014, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_bd", {31'd0, out_bd}, 32'd0);

    // Asynchronous reset with both entries occupied.
    drive(1'b1, 32'h0000_0020, 32'h0000_3020, 5'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0021, 32'h0000_3024, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    chk("ar_instr", out_instr, 32'd0);
    chk("ar_bd", {31'd0, out_bd}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("ar_ready_after", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

`ifdef PIPE_PERF_EN
    drive(1'b1, 32'h0000_0030, 32'h0000_3030, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("perf_stall", stall_cnt, 32'd3);
    chk("perf_bubble_ge2", {31'd0, (bubble_cnt >= 32'd2)}, 32'd1);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stall_cnt_q;
    drive(1'b1, 32'h0000_0031, 32'h0000_3034, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("perf_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
